// File: rtl/wb_host_ctrl_if.sv
// Command/response and Wishbone classic bus bundle for wb_host_ctrl.
// The master modport is the controller's view; slave is the environment's view.
interface wb_host_ctrl_if;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_we_i;
   logic [3:0]  cmd_sel_i;
   logic [31:0] cmd_adr_i;
   logic [31:0] cmd_dat_i;

   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;

   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  rsp_ready_i,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_dat_o, rsp_err_o,
      output rsp_ready_i,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/wb_host_ctrl.sv
// Single-outstanding Wishbone classic host controller.
// Accepts one command, runs one bus cycle with a wait-state timeout,
// and holds the response until the consumer takes it.
module wb_host_ctrl #(
   parameter int TIMEOUT = 255
) (
   input logic           wb_clk_i,
   input logic           wb_rst_i,
   wb_host_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   // Ready is a pure state decode so there is no path from cmd_valid_i.
   assign bus.cmd_ready_o = (state == IDLE);

   // Controller FSM: command capture, bus cycle with timeout, response hold.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         bus.wbm_cyc_o   <= 1'b0;
         bus.wbm_stb_o   <= 1'b0;
         bus.wbm_we_o    <= 1'b0;
         bus.wbm_sel_o   <= '0;
         bus.wbm_adr_o   <= '0;
         bus.wbm_dat_o   <= '0;
         bus.rsp_valid_o <= 1'b0;
         bus.rsp_err_o   <= 1'b0;
         bus.rsp_dat_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid_i) begin
                  bus.wbm_we_o  <= bus.cmd_we_i;
                  bus.wbm_sel_o <= bus.cmd_sel_i;
                  bus.wbm_adr_o <= bus.cmd_adr_i;
                  bus.wbm_dat_o <= bus.cmd_dat_i;
                  bus.wbm_cyc_o <= 1'b1;
                  bus.wbm_stb_o <= 1'b1;
                  wait_cnt      <= '0;
                  state         <= BUS;
               end
            end
            BUS: begin
               // Ack takes priority over a coincident timeout.
               if (bus.wbm_ack_i) begin
                  bus.wbm_cyc_o   <= 1'b0;
                  bus.wbm_stb_o   <= 1'b0;
                  bus.rsp_dat_o   <= bus.wbm_we_o ? 32'd0 : bus.wbm_dat_i;
                  bus.rsp_err_o   <= 1'b0;
                  bus.rsp_valid_o <= 1'b1;
                  state           <= RESP;
               end else begin
                  // Counter is wide enough to hold TIMEOUT, so this never wraps.
                  wait_cnt <= wait_cnt + CNT_W'(1);
                  if (wait_cnt == CNT_LAST) begin
                     bus.wbm_cyc_o   <= 1'b0;
                     bus.wbm_stb_o   <= 1'b0;
                     bus.rsp_dat_o   <= '0;
                     bus.rsp_err_o   <= 1'b1;
                     bus.rsp_valid_o <= 1'b1;
                     state           <= RESP;
                  end
               end
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  bus.rsp_valid_o <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_host_ctrl.md
WB_HOST_CTRL -- requirements
Module: wb_host_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles wbm_cyc_o stays high without wbm_ack_i before abort; legal range 1..65535.
REQ-002 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid_i  in  1  command request.
REQ-005 cmd_ready_o  out  1  block can accept a command.
REQ-006 cmd_we_i  in  1  1=write, 0=read.
REQ-007 cmd_sel_i  in  4  byte lane select.
REQ-008 cmd_adr_i  in  32  byte address.
REQ-009 cmd_dat_i  in  32  write data.
REQ-010 rsp_valid_o  out  1  response available.
REQ-011 rsp_ready_i  in  1  consumer accepts response.
REQ-012 rsp_dat_o  out  32  read data (0 for writes and timeouts).
REQ-013 rsp_err_o  out  1  1=transaction aborted by timeout.
REQ-014 wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone classic cycle/strobe.
REQ-015 wbm_we_o  out  1; wbm_sel_o  out  4; wbm_adr_o  out  32; wbm_dat_o  out  32  Wishbone request fields.
REQ-016 wbm_dat_i  in  32; wbm_ack_i  in  1  Wishbone slave read data and acknowledge.

Function
REQ-017 FSM states IDLE, BUS, RESP; exactly one active.
REQ-018 cmd_ready_o is 1 iff state is IDLE, decoded from state register only (no path from cmd_valid_i).
REQ-019 IDLE: cmd_valid_i=1 at an edge registers we/sel/adr/dat onto wbm_* outputs, sets wbm_cyc_o=wbm_stb_o=1, clears wait counter, enters BUS.
REQ-020 BUS: wbm_cyc_o, wbm_stb_o and all wbm_* request fields held constant; cmd_valid_i ignored.
REQ-021 BUS, wbm_ack_i=1 at an edge: cyc/stb go 0, rsp_dat_o loads wbm_dat_i for reads or 0 for writes, rsp_err_o=0, rsp_valid_o=1, enter RESP.
REQ-022 BUS, wbm_ack_i=0 at an edge: wait counter increments; when counter equals TIMEOUT-1 at that edge, cyc/stb go 0, rsp_dat_o=0, rsp_err_o=1, rsp_valid_o=1, enter RESP.
REQ-023 Ack and timeout in same cycle: ack wins, rsp_err_o=0.
REQ-024 Wait counter width clog2(TIMEOUT+1) bits; never wraps (abort precedes overflow).
REQ-025 Zero-wait slave (ack combinational in first BUS cycle): command edge N, cyc high during cycle N..N+1, rsp_valid_o high after edge N+1; minimum command-to-response latency 2 edges.
REQ-026 RESP: rsp_valid_o, rsp_dat_o, rsp_err_o held stable until rsp_ready_i=1 at an edge; then rsp_valid_o=0, enter IDLE.
REQ-027 Back-to-back: cmd_ready_o rises the cycle after the response handshake; no command accepted while in RESP.
REQ-028 wbm_ack_i outside BUS ignored (no state, counter or response change).
REQ-029 After a cycle ends, wbm_we_o/sel/adr/dat keep last values until next accepted command.

Reset
REQ-030 wb_rst_i=1 forces immediately, without clock: state IDLE, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, counter 0.
REQ-031 Reset during BUS or RESP aborts the transaction with no response issued; first command accepted at first edge after wb_rst_i falls with cmd_valid_i=1.

Verification
REQ-032 Write, zero-wait: cmd we=1 adr=0x3000_0004 sel=0xF dat=0x1234_5678, ack in first BUS cycle -> wbm_* carry those values, one cyc pulse of 1 cycle, rsp_valid with rsp_dat=0, rsp_err=0.
REQ-033 Read, 3 wait states: cmd we=0 adr=0x3000_0010, ack on 4th BUS cycle with wbm_dat_i=0xA5A5_0F0F -> cyc high exactly 4 cycles, rsp_dat=0xA5A5_0F0F, rsp_err=0.
REQ-034 Timeout, TIMEOUT=8, no ack -> cyc high exactly 8 cycles, rsp_err=1, rsp_dat=0; ack at cycle 8 instead -> rsp_err=0.
REQ-035 Backpressure: rsp_ready_i=0 for 5 cycles after response -> rsp fields stable, cmd_ready_o=0, new cmd_valid_i ignored, stray wbm_ack_i ignored; rsp_ready_i=1 -> IDLE next cycle.
REQ-036 Reset mid-BUS: assert wb_rst_i between edges in cycle 2 of a wait-stated read -> cyc/stb 0 asynchronously, no rsp_valid_o; following write completes normally.
